// File: rtl/regfile_scoreboard_pkg.sv
// Shared types for the register-file / scoreboard stage: decoded packet, issued packet, writeback.
// Build option RF_WB_BYPASS_EN (see regfile_scoreboard.sv) does not change any type here.
package regfile_scoreboard_pkg;

  localparam int XLEN             = 32;
  localparam int NUM_REGS_DEFAULT = 32;
  localparam int REG_IDX_W        = $clog2(NUM_REGS_DEFAULT);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      xword_t;

  typedef struct packed {
    xword_t   pc;
    xword_t   imm;
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
    logic     use_rs1;
    logic     use_rs2;
    logic     alu_cmd_vld;
    logic     lsu_cmd_vld;
    logic     br_cmd_vld;
    logic     csr_cmd_vld;
  } id_data_t;

  typedef struct packed {
    id_data_t id_data;
  } idrf_tdata_t;

  typedef struct packed {
    id_data_t id_data;
    xword_t   rs1_data;
    xword_t   rs2_data;
  } rfex_tdata_t;

  typedef struct packed {
    rfex_tdata_t rf_data;
    xword_t      result;
  } ex_data_t;

  typedef struct packed {
    xword_t   wdata;
    ex_data_t ex_data;
  } wbrf_tdata_t;

  // An operand only matters when it is used and not x0.
  function automatic logic operand_live(input logic en, input reg_idx_t idx);
    return en && (idx != '0);
  endfunction

endpackage

// File: rtl/regfile_scoreboard_sb.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on writeback or flush.
// With RF_WB_BYPASS_EN a same-cycle writeback masks its busy bit out of the hazard query.
module regfile_scoreboard_sb
  import regfile_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                set_en_i,
  input  reg_idx_t            set_idx_i,
  input  logic                clr_en_i,
  input  reg_idx_t            clr_idx_i,
  input  logic                use_rs1_i,
  input  reg_idx_t            rs1_i,
  input  logic                use_rs2_i,
  input  reg_idx_t            rs2_i,
  input  reg_idx_t            rd_i,
  output logic                hazard_o,
  output logic [NUM_REGS-1:0] busy_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] blocking;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      if (gi == 0) begin : g_x0
        assign busy_d[gi]   = 1'b0;
        assign blocking[gi] = 1'b0;
      end else begin : g_reg
        localparam reg_idx_t IDX = reg_idx_t'(gi);
        logic set_hit;
        logic clr_hit;
        assign set_hit    = set_en_i && (set_idx_i == IDX);
        assign clr_hit    = clr_en_i && (clr_idx_i == IDX);
        // Set is applied after clear so an issue and a writeback to the same rd leave it busy.
        assign busy_d[gi] = set_hit || (busy_q[gi] && !clr_hit);
`ifdef RF_WB_BYPASS_EN
        assign blocking[gi] = busy_q[gi] && !clr_hit;
`else
        assign blocking[gi] = busy_q[gi];
`endif
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign hazard_o = (use_rs1_i && blocking[rs1_i])
                 || (use_rs2_i && blocking[rs2_i])
                 || blocking[rd_i];
  assign busy_o   = busy_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with pending-write scoreboard and a single-entry issue slot toward EX.
// Optional RF_WB_BYPASS_EN: forward same-cycle writeback into operand reads and the hazard check.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        idrf_tvalid_i,
  output logic        idrf_tready_o,
  input  idrf_tdata_t idrf_tdata_i,
  output logic        rfex_tvalid_o,
  input  logic        rfex_tready_i,
  output rfex_tdata_t rfex_tdata_o,
  input  logic        wbrf_tvalid_i,
  output logic        wbrf_tready_o,
  input  wbrf_tdata_t wbrf_tdata_i,
  input  logic        flush
);

  xword_t              regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                hazard;
  logic                rfex_tvalid_q;
  rfex_tdata_t         rfex_tdata_q;
  rfex_tdata_t         rfex_tdata_d;
  logic                out_free;
  logic                issue;
  logic                wb_write;
  reg_idx_t            wb_rd;
  xword_t              wb_wdata;
  id_data_t            id;
  logic                wb_unused;

  assign id        = idrf_tdata_i.id_data;
  assign wb_rd     = wbrf_tdata_i.ex_data.rf_data.id_data.rd;
  assign wb_wdata  = wbrf_tdata_i.wdata;
  assign wb_write  = wbrf_tvalid_i && (wb_rd != '0);
  assign wb_unused = ^{wbrf_tdata_i.ex_data.result, wbrf_tdata_i.ex_data.rf_data.rs1_data,
                       wbrf_tdata_i.ex_data.rf_data.rs2_data};

  assign wbrf_tready_o = 1'b1;
  assign out_free      = !rfex_tvalid_q || rfex_tready_i;
  assign idrf_tready_o = !rst && out_free && !hazard && !flush;
  assign issue         = idrf_tvalid_i && idrf_tready_o;

  regfile_scoreboard_sb #(
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush),
    .set_en_i  (issue),
    .set_idx_i (id.rd),
    .clr_en_i  (wb_write),
    .clr_idx_i (wb_rd),
    .use_rs1_i (id.use_rs1),
    .rs1_i     (id.rs1),
    .use_rs2_i (id.use_rs2),
    .rs2_i     (id.rs2),
    .rd_i      (id.rd),
    .hazard_o  (hazard),
    .busy_o    (busy)
  );

  // Writebacks land even in a flush cycle: the flushing instruction itself commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_write) begin
      regs_q[wb_rd] <= wb_wdata;
    end
  end

  always_comb begin
    rfex_tdata_d          = '0;
    rfex_tdata_d.id_data  = id;
    if (operand_live(id.use_rs1, id.rs1)) begin
      rfex_tdata_d.rs1_data = regs_q[id.rs1];
`ifdef RF_WB_BYPASS_EN
      if (wb_write && (wb_rd == id.rs1)) begin
        rfex_tdata_d.rs1_data = wb_wdata;
      end
`endif
    end
    if (operand_live(id.use_rs2, id.rs2)) begin
      rfex_tdata_d.rs2_data = regs_q[id.rs2];
`ifdef RF_WB_BYPASS_EN
      if (wb_write && (wb_rd == id.rs2)) begin
        rfex_tdata_d.rs2_data = wb_wdata;
      end
`endif
    end
  end

  // Payload only changes on issue, so it stays stable while the slot is back-pressured.
  always_ff @(posedge clk) begin
    if (rst) begin
      rfex_tvalid_q <= 1'b0;
      rfex_tdata_q  <= '0;
    end else if (flush) begin
      rfex_tvalid_q <= 1'b0;
    end else if (issue) begin
      rfex_tvalid_q <= 1'b1;
      rfex_tdata_q  <= rfex_tdata_d;
    end else if (rfex_tready_i) begin
      rfex_tvalid_q <= 1'b0;
    end
  end

  assign rfex_tvalid_o = rfex_tvalid_q;
  assign rfex_tdata_o  = rfex_tdata_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard; expectations follow RF_WB_BYPASS_EN if defined.
module tb_regfile_scoreboard;
  import regfile_scoreboard_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        idrf_tvalid;
  logic        idrf_tready;
  idrf_tdata_t idrf_tdata;
  logic        rfex_tvalid;
  logic        rfex_tready;
  rfex_tdata_t rfex_tdata;
  logic        wbrf_tvalid;
  logic        wbrf_tready;
  wbrf_tdata_t wbrf_tdata;
  logic        flush;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.NUM_REGS(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .idrf_tvalid_i (idrf_tvalid),
    .idrf_tready_o (idrf_tready),
    .idrf_tdata_i  (idrf_tdata),
    .rfex_tvalid_o (rfex_tvalid),
    .rfex_tready_i (rfex_tready),
    .rfex_tdata_o  (rfex_tdata),
    .wbrf_tvalid_i (wbrf_tvalid),
    .wbrf_tready_o (wbrf_tready),
    .wbrf_tdata_i  (wbrf_tdata),
    .flush         (flush)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic half();
    #4;
  endtask

  function automatic idrf_tdata_t mk_id(input reg_idx_t rs1, input logic u1,
                                        input reg_idx_t rs2, input logic u2, input reg_idx_t rd);
    idrf_tdata_t p;
    p = '0;
    p.id_data.pc          = 32'h1000 + 32'(rd) * 4;
    p.id_data.imm         = 32'h0000_0042;
    p.id_data.rs1         = rs1;
    p.id_data.use_rs1     = u1;
    p.id_data.rs2         = rs2;
    p.id_data.use_rs2     = u2;
    p.id_data.rd          = rd;
    p.id_data.alu_cmd_vld = 1'b1;
    return p;
  endfunction

  task automatic drive_wb(input logic v, input reg_idx_t rd, input xword_t d);
    wbrf_tvalid = v;
    wbrf_tdata  = '0;
    wbrf_tdata.wdata = d;
    wbrf_tdata.ex_data.rf_data.id_data.rd = rd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idrf_tvalid = 1'b1;
    idrf_tdata = mk_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd3);
    step();
    half();
    tests++;
    if (idrf_tready !== 1'b0) begin fails++; $display("FAIL reset_idrf_tready got %b want 0", idrf_tready); end
    tests++;
    if (wbrf_tready !== 1'b1) begin fails++; $display("FAIL wbrf_tready got %b want 1", wbrf_tready); end
    step();
    rst = 1'b0;
    idrf_tvalid = 1'b0;
    tests++;
    if (rfex_tvalid !== 1'b0 || rfex_tdata !== '0)
      begin fails++; $display("FAIL reset_rfex got v=%b d=%h want 0", rfex_tvalid, rfex_tdata); end
    tests++;
    if (dut.busy !== '0 || dut.regs_q[5] !== '0)
      begin fails++; $display("FAIL reset_state got busy=%h r5=%h want 0", dut.busy, dut.regs_q[5]); end
    $display("[TB] reset done");
  endtask

  task automatic test_basic_issue();
    drive_wb(1'b1, 5'd5, 32'hDEAD_BEEF);
    step();
    drive_wb(1'b0, 5'd0, 32'h0);
    idrf_tvalid = 1'b1;
    idrf_tdata = mk_id(5'd5, 1'b1, 5'd0, 1'b1, 5'd6);
    half();
    tests++;
    if (idrf_tready !== 1'b1 || rfex_tvalid !== 1'b0)
      begin fails++; $display("FAIL basic_accept got rdy=%b v=%b want 1 0", idrf_tready, rfex_tvalid); end
    step();
    idrf_tvalid = 1'b0;
    $display("[TB] issue rd=%0d rs1=%h rs2=%h", rfex_tdata.id_data.rd, rfex_tdata.rs1_data, rfex_tdata.rs2_data);
    tests++;
    if (rfex_tvalid !== 1'b1 || rfex_tdata.rs1_data !== 32'hDEAD_BEEF || rfex_tdata.rs2_data !== 32'h0
        || rfex_tdata.id_data.rd !== 5'd6 || rfex_tdata.id_data.pc !== 32'h1018)
      begin fails++; $display("FAIL basic_issue got v=%b rs1=%h rs2=%h rd=%0d want 1 deadbeef 0 6",
                              rfex_tvalid, rfex_tdata.rs1_data, rfex_tdata.rs2_data, rfex_tdata.id_data.rd); end
    tests++;
    if (dut.busy[6] !== 1'b1) begin fails++; $display("FAIL basic_busy6 got %b want 1", dut.busy[6]); end
    step();
    tests++;
    if (rfex_tvalid !== 1'b0) begin fails++; $display("FAIL basic_drain got %b want 0", rfex_tvalid); end
    drive_wb(1'b1, 5'd6, 32'h66);
    step();
    drive_wb(1'b0, 5'd0, 32'h0);
    tests++;
    if (dut.busy !== '0) begin fails++; $display("FAIL basic_clear got %h want 0", dut.busy); end
  endtask

  task automatic test_raw();
    idrf_tvalid = 1'b1;
    idrf_tdata = mk_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd3);
    step();
    idrf_tdata = mk_id(5'd3, 1'b1, 5'd0, 1'b0, 5'd8);
    half();
    tests++;
    if (idrf_tready !== 1'b0) begin fails++; $display("FAIL raw_stall0 got %b want 0", idrf_tready); end
    step();
    half();
    tests++;
    if (idrf_tready !== 1'b0) begin fails++; $display("FAIL raw_stall1 got %b want 0", idrf_tready); end
    step();
    drive_wb(1'b1, 5'd3, 32'h11);
    half();
    tests++;
`ifdef RF_WB_BYPASS_EN
    if (idrf_tready !== 1'b1) begin fails++; $display("FAIL raw_wb_cycle got %b want 1", idrf_tready); end
    step();
    drive_wb(1'b0, 5'd0, 32'h0);
`else
    if (idrf_tready !== 1'b0) begin fails++; $display("FAIL raw_wb_cycle got %b want 0", idrf_tready); end
    step();
    drive_wb(1'b0, 5'd0, 32'h0);
    half();
    tests++;
    if (idrf_tready !== 1'b1) begin fails++; $display("FAIL raw_after_wb got %b want 1", idrf_tready); end
    step();
`endif
    idrf_tvalid = 1'b0;
    $display("[TB] issue rd=%0d rs1=%h", rfex_tdata.id_data.rd, rfex_tdata.rs1_data);
    tests++;
    if (rfex_tvalid !== 1'b1 || rfex_tdata.rs1_data !== 32'h11 || rfex_tdata.id_data.rd !== 5'd8)
      begin fails++; $display("FAIL raw_issue got v=%b rs1=%h rd=%0d want 1 11 8",
                              rfex_tvalid, rfex_tdata.rs1_data, rfex_tdata.id_data.rd); end
    tests++;
    if (dut.busy[3] !== 1'b0 || dut.busy[8] !== 1'b1)
      begin fails++; $display("FAIL raw_busy got b3=%b b8=%b want 0 1", dut.busy[3], dut.busy[8]); end
    drive_wb(1'b1, 5'd8, 32'h88);
    step();
    drive_wb(1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_waw();
    idrf_tvalid = 1'b1;
    idrf_tdata = mk_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd7);
    step();
    half();
    tests++;
    if (idrf_tready !== 1'b0) begin fails++; $display("FAIL waw_stall got %b want 0", idrf_tready); end
    step();
    drive_wb(1'b1, 5'd7, 32'h77);
    half();
    tests++;
`ifdef RF_WB_BYPASS_EN
    if (idrf_tready !== 1'b1) begin fails++; $display("FAIL waw_wb_cycle got %b want 1", idrf_tready); end
    step();
    drive_wb(1'b0, 5'd0, 32'h0);
`else
    if (idrf_tready !== 1'b0) begin fails++; $display("FAIL waw_wb_cycle got %b want 0", idrf_tready); end
    step();
    drive_wb(1'b0, 5'd0, 32'h0);
    step();
`endif
    idrf_tvalid = 1'b0;
    $display("[TB] issue rd=%0d", rfex_tdata.id_data.rd);
    tests++;
    if (rfex_tvalid !== 1'b1 || dut.busy[7] !== 1'b1 || dut.regs_q[7] !== 32'h77)
      begin fails++; $display("FAIL waw_issue got v=%b b7=%b r7=%h want 1 1 77",
                              rfex_tvalid, dut.busy[7], dut.regs_q[7]); end
    drive_wb(1'b1, 5'd7, 32'h78);
    step();
    drive_wb(1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_x0();
    drive_wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    step();
    drive_wb(1'b0, 5'd0, 32'h0);
    tests++;
    if (dut.regs_q[0] !== 32'h0) begin fails++; $display("FAIL x0_write got %h want 0", dut.regs_q[0]); end
    idrf_tvalid = 1'b1;
    idrf_tdata = mk_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
    step();
    idrf_tdata = mk_id(5'd5, 1'b0, 5'd5, 1'b1, 5'd0);
    tests++;
    if (rfex_tvalid !== 1'b1 || rfex_tdata.rs1_data !== 32'h0 || rfex_tdata.rs2_data !== 32'h0 || dut.busy !== '0)
      begin fails++; $display("FAIL x0_read got rs1=%h rs2=%h busy=%h want 0 0 0",
                              rfex_tdata.rs1_data, rfex_tdata.rs2_data, dut.busy); end
    step();
    idrf_tvalid = 1'b0;
    tests++;
    if (rfex_tdata.rs1_data !== 32'h0 || rfex_tdata.rs2_data !== 32'hDEAD_BEEF)
      begin fails++; $display("FAIL unused_operand got rs1=%h rs2=%h want 0 deadbeef",
                              rfex_tdata.rs1_data, rfex_tdata.rs2_data); end
    step();
  endtask

  task automatic test_back_pressure();
    rfex_tdata_t exp_a;
    idrf_tdata_t pkt_a;
    pkt_a = mk_id(5'd5, 1'b1, 5'd0, 1'b0, 5'd10);
    exp_a = '0;
    exp_a.id_data  = pkt_a.id_data;
    exp_a.rs1_data = 32'hDEAD_BEEF;
    rfex_tready = 1'b0;
    idrf_tvalid = 1'b1;
    idrf_tdata = pkt_a;
    step();
    idrf_tdata = mk_id(5'd0, 1'b0, 5'd5, 1'b1, 5'd11);
    for (int k = 0; k < 3; k++) begin
      half();
      tests++;
      if (idrf_tready !== 1'b0 || rfex_tvalid !== 1'b1 || rfex_tdata !== exp_a)
        begin fails++; $display("FAIL bp_hold%0d got rdy=%b v=%b d=%h want 0 1 %h",
                                k, idrf_tready, rfex_tvalid, rfex_tdata, exp_a); end
      step();
    end
    rfex_tready = 1'b1;
    half();
    tests++;
    if (idrf_tready !== 1'b1) begin fails++; $display("FAIL bp_release got %b want 1", idrf_tready); end
    step();
    idrf_tvalid = 1'b0;
    $display("[TB] issue rd=%0d rs2=%h", rfex_tdata.id_data.rd, rfex_tdata.rs2_data);
    tests++;
    if (rfex_tvalid !== 1'b1 || rfex_tdata.id_data.rd !== 5'd11 || rfex_tdata.rs2_data !== 32'hDEAD_BEEF)
      begin fails++; $display("FAIL bp_next got v=%b rd=%0d rs2=%h want 1 11 deadbeef",
                              rfex_tvalid, rfex_tdata.id_data.rd, rfex_tdata.rs2_data); end
    drive_wb(1'b1, 5'd10, 32'hA);
    step();
    drive_wb(1'b1, 5'd11, 32'hB);
    step();
    drive_wb(1'b0, 5'd0, 32'h0);
    tests++;
    if (dut.busy !== '0) begin fails++; $display("FAIL bp_clear got %h want 0", dut.busy); end
  endtask

  task automatic test_flush();
    rfex_tready = 1'b1;
    idrf_tvalid = 1'b1;
    idrf_tdata = mk_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd4);
    step();
    idrf_tdata = mk_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd9);
    step();
    idrf_tvalid = 1'b0;
    rfex_tready = 1'b0;
    tests++;
    if (dut.busy[4] !== 1'b1 || dut.busy[9] !== 1'b1 || rfex_tvalid !== 1'b1)
      begin fails++; $display("FAIL flush_setup got b4=%b b9=%b v=%b want 1 1 1",
                              dut.busy[4], dut.busy[9], rfex_tvalid); end
    rfex_tready = 1'b1;
    flush = 1'b1;
    drive_wb(1'b1, 5'd4, 32'h22);
    idrf_tvalid = 1'b1;
    idrf_tdata = mk_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd12);
    half();
    tests++;
    if (idrf_tready !== 1'b0) begin fails++; $display("FAIL flush_no_issue got %b want 0", idrf_tready); end
    step();
    flush = 1'b0;
    drive_wb(1'b0, 5'd0, 32'h0);
    idrf_tvalid = 1'b0;
    tests++;
    if (dut.busy !== '0 || rfex_tvalid !== 1'b0 || dut.regs_q[4] !== 32'h22)
      begin fails++; $display("FAIL flush_result got busy=%h v=%b r4=%h want 0 0 22",
                              dut.busy, rfex_tvalid, dut.regs_q[4]); end
    $display("[TB] flush done");
  endtask

  task automatic test_mid_reset();
    idrf_tvalid = 1'b1;
    idrf_tdata = mk_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd13);
    step();
    idrf_tvalid = 1'b0;
    rfex_tready = 1'b0;
    tests++;
    if (dut.busy[13] !== 1'b1 || rfex_tvalid !== 1'b1)
      begin fails++; $display("FAIL midrst_setup got b13=%b v=%b want 1 1", dut.busy[13], rfex_tvalid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if (dut.busy !== '0 || rfex_tvalid !== 1'b0 || rfex_tdata !== '0 || dut.regs_q[5] !== '0)
      begin fails++; $display("FAIL midrst_state got busy=%h v=%b r5=%h want 0 0 0",
                              dut.busy, rfex_tvalid, dut.regs_q[5]); end
    rfex_tready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idrf_tvalid = 1'b0;
    idrf_tdata = '0;
    rfex_tready = 1'b1;
    wbrf_tvalid = 1'b0;
    wbrf_tdata = '0;
    flush = 1'b0;
    #1;
    test_reset();
    test_basic_issue();
    test_raw();
    test_waw();
    test_x0();
    test_back_pressure();
    test_flush();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
